// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared types for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (IDLE / REQ / HOLD / HALT).
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // first cycle after reset, no request yet
    ST_REQ  = 2'd1,  // read request outstanding on the memory port
    ST_HOLD = 2'd2,  // a fetched word waits in the buffer while stalled
    ST_HALT = 2'd3   // processor halted; left only through reset
  } fetch_state_e;

  localparam int unsigned FETCH_WORD_W = 16;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// if_id_register
//   IF/ID pipeline register: valid bit, instruction word and fetch PC + 1.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     load                capture {1, load_inst, load_pc_next}
//     clear               drop the valid bit (bubble); wins over load
//     load_inst/pc_next   data to capture
//     valid/inst/pc_next  registered outputs
//   With neither load nor clear the contents are held.
module if_id_register #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] load_inst,
  input  logic [WORD_W-1:0] load_pc_next,
  output logic              valid,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] pc_next
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] inst_q, inst_d;
  logic [WORD_W-1:0] pc_next_q, pc_next_d;

  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    pc_next_d = pc_next_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      inst_d    = load_inst;
      pc_next_d = load_pc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      inst_q    <= '0;
      pc_next_q <= '0;
    end else begin
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      pc_next_q <= pc_next_d;
    end
  end

  assign valid   = valid_q;
  assign inst    = inst_q;
  assign pc_next = pc_next_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage: owns the PC, drives the instruction-memory
//   handshake and loads the IF/ID register.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     i_readM/i_address            memory read request / address (= pc)
//     i_data/i_inputReady          returned word / 1-cycle completion pulse
//     stall, flush                 hold IF/ID+PC / kill IF/ID contents
//     redirect_en/redirect_pc      load PC with a branch/jump target
//     halt                         stop fetching until reset
//     if_id_valid/inst/pc_next     IF/ID register outputs
//     num_fetched                  instructions delivered to IF/ID (wraps)
//     dbg_state                    current FSM state
//   Memory handshake: i_readM is high in every REQ cycle; a word is taken
//   only on a cycle where i_readM=1 and i_inputReady=1, and is consumed in
//   that same cycle (either into IF/ID or into the stall buffer).
//   Per-cycle priority: halt > redirect_en > flush > stall > normal fetch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                WORD_W   = FETCH_WORD_W,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              i_readM,
  output logic [WORD_W-1:0] i_address,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_inputReady,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_en,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              if_id_valid,
  output logic [WORD_W-1:0] if_id_inst,
  output logic [WORD_W-1:0] if_id_pc_next,
  output logic [WORD_W-1:0] num_fetched,
  output fetch_state_e      dbg_state
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;

  logic              ifid_load;
  logic              ifid_clear;
  logic [WORD_W-1:0] pc_inc;
  logic [WORD_W-1:0] load_inst;

  // Wraps naturally at WORD_W bits; the same value is the link/branch base.
  assign pc_inc    = pc_q + 1'b1;
  // In HOLD the delivered word comes from the buffer, otherwise from memory.
  assign load_inst = (state_q == ST_HOLD) ? buf_q : i_data;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;

    if (state_q != ST_HALT) begin
      if (halt) begin
        state_d    = ST_HALT;
        ifid_clear = 1'b1;
      end else if (redirect_en) begin
        // Any in-flight or buffered word belongs to the wrong path.
        pc_d       = redirect_pc;
        ifid_clear = 1'b1;
        state_d    = ST_REQ;
      end else if (flush) begin
        // Arriving or buffered word is dropped; pc unchanged so it is re-fetched.
        ifid_clear = 1'b1;
        state_d    = ST_REQ;
      end else begin
        case (state_q)
          ST_IDLE: state_d = ST_REQ;
          ST_REQ: begin
            if (i_inputReady) begin
              if (!stall) begin
                ifid_load = 1'b1;
                pc_d      = pc_inc;
                cnt_d     = cnt_q + 1'b1;
              end else begin
                buf_d   = i_data;
                state_d = ST_HOLD;
              end
            end else if (!stall) begin
              ifid_clear = 1'b1;
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              ifid_load = 1'b1;
              pc_d      = pc_inc;
              cnt_d     = cnt_q + 1'b1;
              state_d   = ST_REQ;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_register #(.WORD_W(WORD_W)) u_if_id (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (ifid_load),
    .clear        (ifid_clear),
    .load_inst    (load_inst),
    .load_pc_next (pc_inc),
    .valid        (if_id_valid),
    .inst         (if_id_inst),
    .pc_next      (if_id_pc_next)
  );

  assign i_readM     = (state_q == ST_REQ);
  assign i_address   = pc_q;
  assign num_fetched = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         i_readM;
  logic [15:0]  i_address;
  logic [15:0]  i_data;
  logic         i_inputReady;
  logic         stall;
  logic         flush;
  logic         redirect_en;
  logic [15:0]  redirect_pc;
  logic         halt;
  logic         if_id_valid;
  logic [15:0]  if_id_inst;
  logic [15:0]  if_id_pc_next;
  logic [15:0]  num_fetched;
  fetch_state_e dbg_state;

  int checks;
  int failures;

  // Scoreboard: {inst, pc_next} expected per delivery, in order.
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [15:0] m_pc;
  logic [15:0] m_cnt;

  fetch_stage #(.WORD_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_readM       (i_readM),
    .i_address     (i_address),
    .i_data        (i_data),
    .i_inputReady  (i_inputReady),
    .stall         (stall),
    .flush         (flush),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .if_id_valid   (if_id_valid),
    .if_id_inst    (if_id_inst),
    .if_id_pc_next (if_id_pc_next),
    .num_fetched   (num_fetched),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_data       = 16'h0000;
    i_inputReady = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    redirect_en  = 1'b0;
    redirect_pc  = 16'h0000;
    halt         = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    m_pc  = 16'h0000;
    m_cnt = 16'h0000;
  endtask

  // ---------------- driver tasks ----------------
  // One memory completion that the DUT must deliver straight into IF/ID.
  task automatic drive_delivery(input logic [15:0] w);
    i_data       = w;
    i_inputReady = 1'b1;
    exp_q.push_back({w, m_pc + 16'd1});
    m_pc  = m_pc + 16'd1;
    m_cnt = m_cnt + 16'd1;
    tick();
    i_inputReady = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #2;
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    checks++; if (i_readM !== 1'b0) begin failures++; $display("FAIL reset_readM: got %b expected 0", i_readM); end
    checks++; if (i_address !== 16'h0000) begin failures++; $display("FAIL reset_address: got %h expected 0000", i_address); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
    checks++; if (if_id_inst !== 16'h0000) begin failures++; $display("FAIL reset_inst: got %h expected 0000", if_id_inst); end
    checks++; if (if_id_pc_next !== 16'h0000) begin failures++; $display("FAIL reset_pc_next: got %h expected 0000", if_id_pc_next); end
    checks++; if (num_fetched !== 16'h0000) begin failures++; $display("FAIL reset_num: got %h expected 0000", num_fetched); end
    apply_reset();
    // Reset was released just after a rising edge; the next edge moves IDLE->REQ.
    tick();
    checks++; if (dbg_state !== ST_REQ) begin failures++; $display("FAIL idle_to_req: got %0d expected %0d", dbg_state, ST_REQ); end
    checks++; if (i_readM !== 1'b1) begin failures++; $display("FAIL readM_in_req: got %b expected 1", i_readM); end
  endtask

  task automatic test_basic_fetch();
    // memory answers after two cycles
    tick();
    tick();
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL wait_valid: got %b expected 0", if_id_valid); end
    drive_delivery(16'h6001);
    checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", if_id_valid); end
    exp_v = exp_q.pop_front();
    checks++; if ({if_id_inst, if_id_pc_next} !== exp_v) begin failures++; $display("FAIL basic_ifid: got %h expected %h", {if_id_inst, if_id_pc_next}, exp_v); end
    checks++; if (i_address !== m_pc) begin failures++; $display("FAIL basic_pc: got %h expected %h", i_address, m_pc); end
    checks++; if (num_fetched !== m_cnt) begin failures++; $display("FAIL basic_num: got %h expected %h", num_fetched, m_cnt); end
    // no word this cycle -> bubble
    tick();
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid: got %b expected 0", if_id_valid); end
    checks++; if (i_address !== m_pc) begin failures++; $display("FAIL bubble_pc: got %h expected %h", i_address, m_pc); end
  endtask

  task automatic test_stall_hold();
    stall        = 1'b1;
    i_data       = 16'hF01C;
    i_inputReady = 1'b1;
    tick();
    i_inputReady = 1'b0;
    checks++; if (dbg_state !== ST_HOLD) begin failures++; $display("FAIL hold_state: got %0d expected %0d", dbg_state, ST_HOLD); end
    checks++; if (i_readM !== 1'b0) begin failures++; $display("FAIL hold_readM: got %b expected 0", i_readM); end
    checks++; if (i_address !== m_pc) begin failures++; $display("FAIL hold_pc: got %h expected %h", i_address, m_pc); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL hold_valid: got %b expected 0", if_id_valid); end
    // inputReady outside REQ must be ignored
    i_data       = 16'hBEEF;
    i_inputReady = 1'b1;
    tick();
    i_inputReady = 1'b0;
    checks++; if (dbg_state !== ST_HOLD) begin failures++; $display("FAIL hold_stays: got %0d expected %0d", dbg_state, ST_HOLD); end
    checks++; if (num_fetched !== m_cnt) begin failures++; $display("FAIL hold_num: got %h expected %h", num_fetched, m_cnt); end
    // release: the buffered word is delivered
    stall = 1'b0;
    exp_q.push_back({16'hF01C, m_pc + 16'd1});
    m_pc  = m_pc + 16'd1;
    m_cnt = m_cnt + 16'd1;
    tick();
    checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL release_valid: got %b expected 1", if_id_valid); end
    exp_v = exp_q.pop_front();
    checks++; if ({if_id_inst, if_id_pc_next} !== exp_v) begin failures++; $display("FAIL release_ifid: got %h expected %h", {if_id_inst, if_id_pc_next}, exp_v); end
    checks++; if (i_address !== m_pc) begin failures++; $display("FAIL release_pc: got %h expected %h", i_address, m_pc); end
    checks++; if (dbg_state !== ST_REQ) begin failures++; $display("FAIL release_state: got %0d expected %0d", dbg_state, ST_REQ); end
  endtask

  task automatic test_redirect();
    i_data       = 16'h1234;
    i_inputReady = 1'b1;
    redirect_en  = 1'b1;
    redirect_pc  = 16'h0040;
    tick();
    i_inputReady = 1'b0;
    redirect_en  = 1'b0;
    m_pc = 16'h0040;
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL redir_valid: got %b expected 0", if_id_valid); end
    checks++; if (i_address !== 16'h0040) begin failures++; $display("FAIL redir_pc: got %h expected 0040", i_address); end
    checks++; if (num_fetched !== m_cnt) begin failures++; $display("FAIL redir_num: got %h expected %h", num_fetched, m_cnt); end
    // redirect beats stall while a word sits in the buffer
    stall        = 1'b1;
    i_data       = 16'h5555;
    i_inputReady = 1'b1;
    tick();
    i_inputReady = 1'b0;
    redirect_en  = 1'b1;
    redirect_pc  = 16'h0080;
    tick();
    redirect_en = 1'b0;
    m_pc = 16'h0080;
    checks++; if (dbg_state !== ST_REQ) begin failures++; $display("FAIL redir_stall_state: got %0d expected %0d", dbg_state, ST_REQ); end
    checks++; if (i_address !== 16'h0080) begin failures++; $display("FAIL redir_stall_pc: got %h expected 0080", i_address); end
    stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL b2b_bubble[%0d]: got %b expected 0", i, if_id_valid); end
      end
      w = 16'($urandom_range(0, 65535));
      drive_delivery(w);
      exp_v = exp_q.pop_front();
      checks++; if ({if_id_valid, if_id_inst, if_id_pc_next} !== {1'b1, exp_v}) begin failures++; $display("FAIL b2b_ifid[%0d]: got %h expected %h", i, {if_id_valid, if_id_inst, if_id_pc_next}, {1'b1, exp_v}); end
      checks++; if ({i_address, num_fetched} !== {m_pc, m_cnt}) begin failures++; $display("FAIL b2b_pc_num[%0d]: got %h expected %h", i, {i_address, num_fetched}, {m_pc, m_cnt}); end
    end
  endtask

  task automatic test_flush();
    i_data       = 16'hAAAA;
    i_inputReady = 1'b1;
    flush        = 1'b1;
    tick();
    i_inputReady = 1'b0;
    flush        = 1'b0;
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", if_id_valid); end
    checks++; if (i_address !== m_pc) begin failures++; $display("FAIL flush_pc: got %h expected %h", i_address, m_pc); end
    checks++; if (num_fetched !== m_cnt) begin failures++; $display("FAIL flush_num: got %h expected %h", num_fetched, m_cnt); end
  endtask

  task automatic test_wrap();
    redirect_en = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect_en = 1'b0;
    m_pc = 16'hFFFF;
    drive_delivery(16'h7777);
    exp_v = exp_q.pop_front();
    checks++; if ({if_id_inst, if_id_pc_next} !== exp_v) begin failures++; $display("FAIL wrap_ifid: got %h expected %h", {if_id_inst, if_id_pc_next}, exp_v); end
    checks++; if (i_address !== 16'h0000) begin failures++; $display("FAIL wrap_pc: got %h expected 0000", i_address); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++; if (dbg_state !== ST_HALT) begin failures++; $display("FAIL halt_state: got %0d expected %0d", dbg_state, ST_HALT); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL halt_valid: got %b expected 0", if_id_valid); end
    for (int i = 0; i < 4; i++) begin
      i_data       = 16'h2222;
      i_inputReady = 1'b1;
      redirect_en  = (i % 2) == 0;
      redirect_pc  = 16'h1234;
      tick();
      checks++; if ({i_readM, i_address, num_fetched} !== {1'b0, m_pc, m_cnt}) begin failures++; $display("FAIL halt_frozen[%0d]: got %h expected %h", i, {i_readM, i_address, num_fetched}, {1'b0, m_pc, m_cnt}); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    tick();
    drive_delivery(16'h4321);
    exp_v = exp_q.pop_front();
    checks++; if ({if_id_inst, if_id_pc_next} !== exp_v) begin failures++; $display("FAIL pre_reset_ifid: got %h expected %h", {if_id_inst, if_id_pc_next}, exp_v); end
    stall        = 1'b1;
    i_data       = 16'h9999;
    i_inputReady = 1'b1;
    tick();
    i_inputReady = 1'b0;
    checks++; if (dbg_state !== ST_HOLD) begin failures++; $display("FAIL pre_reset_hold: got %0d expected %0d", dbg_state, ST_HOLD); end
    // asynchronous reset between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({i_readM, i_address, if_id_valid, if_id_inst, if_id_pc_next, num_fetched} !== 50'd0) begin failures++; $display("FAIL async_reset_outputs: got %h expected 0", {i_readM, i_address, if_id_valid, if_id_inst, if_id_pc_next, num_fetched}); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL async_reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    stall = 1'b0;
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    m_pc     = 16'h0000;
    m_cnt    = 16'h0000;
    clear_inputs();
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_redirect();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_halt();
    test_reset_mid_hold();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
